// File: rtl/ahb_arbiter_if.sv
// Bus-side signal bundle for the two-master AHB arbiter.
// The master modport is the requesting/bus side; the slave modport is the arbiter.
interface ahb_arbiter_if;
  logic [1:0] HBUSREQ;
  logic [1:0] HLOCK;
  logic [1:0] HTRANS;
  logic       HREADY;
  logic [1:0] HGRANT;
  logic       HMASTER;
  logic       HMASTER_D;
  logic       HMASTLOCK;

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HREADY,
    input  HGRANT, HMASTER, HMASTER_D, HMASTLOCK
  );

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HREADY,
    output HGRANT, HMASTER, HMASTER_D, HMASTLOCK
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Two-master round-robin AHB arbiter with locked tenures and a per-tenure beat limit.
// All state advances only on HREADY=1 edges, so a stalled bus freezes the whole arbiter.
module ahb_arbiter #(
  parameter int BURST_MAX = 16
) (
  input logic         HCLK,
  input logic         HRESETn,
  ahb_arbiter_if.slave bus
);
  localparam int CW = (BURST_MAX > 2) ? $clog2(BURST_MAX) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX - 1);

  localparam logic [1:0] PARK = 2'd0;
  localparam logic [1:0] OWN  = 2'd1;
  localparam logic [1:0] LOCK = 2'd2;

  logic [1:0]    state, state_nx;
  logic          gnt, gnt_nx;
  logic [CW-1:0] cnt, cnt_step, cnt_nx;
  logic          hmaster, hmaster_d, mastlock;
  logic          beat, any_req, win, limit, own_rel;

  always_comb begin
    beat    = bus.HTRANS[1];
    any_req = |bus.HBUSREQ;
    // Round-robin: the master that was not last granted has priority.
    win     = bus.HBUSREQ[~gnt] ? ~gnt : (bus.HBUSREQ[gnt] ? gnt : 1'b0);

    cnt_step = cnt;
    if (beat) begin
      if (!bus.HTRANS[0])      cnt_step = '0;
      else if (cnt != CNT_MAX) cnt_step = cnt + 1'b1;
    end

    limit   = beat && (cnt_step == CNT_MAX) && bus.HBUSREQ[~gnt];
    own_rel = !bus.HBUSREQ[gnt] || limit;

    state_nx = state;
    gnt_nx   = gnt;
    case (state)
      PARK: if (any_req) begin
        gnt_nx   = win;
        state_nx = OWN;
      end
      OWN: begin
        if (bus.HBUSREQ[gnt] && bus.HLOCK[gnt]) begin
          state_nx = LOCK;
        end else if (own_rel) begin
          gnt_nx   = win;
          state_nx = any_req ? OWN : PARK;
        end
      end
      LOCK: if (!bus.HLOCK[gnt]) begin
        // Lock release falls straight through to the normal ownership rules.
        state_nx = OWN;
        if (own_rel) begin
          gnt_nx   = win;
          state_nx = any_req ? OWN : PARK;
        end
      end
      default: begin
        state_nx = PARK;
        gnt_nx   = 1'b0;
      end
    endcase

    cnt_nx = (gnt_nx != gnt) ? '0 : cnt_step;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= PARK;
      gnt       <= 1'b0;
      cnt       <= '0;
      hmaster   <= 1'b0;
      hmaster_d <= 1'b0;
      mastlock  <= 1'b0;
    end else if (bus.HREADY) begin
      state     <= state_nx;
      gnt       <= gnt_nx;
      cnt       <= cnt_nx;
      hmaster   <= gnt;
      hmaster_d <= hmaster;
      mastlock  <= bus.HLOCK[gnt];
    end
  end

  assign bus.HGRANT    = {gnt, ~gnt};
  assign bus.HMASTER   = hmaster;
  assign bus.HMASTER_D = hmaster_d;
  assign bus.HMASTLOCK = mastlock;
endmodule
